// File: rtl/spm_operand_serializer.sv
// spm_operand_serializer
// Turns a parallel two's-complement operand into an LSB-first serial frame
// of FRAME_LEN bits, one bit per clock, for the serial-parallel multiplier.
// Optional build macro: SPM_SERIALIZER_ABS_EN
//   undefined -> the frame is the sign-extended operand
//   defined   -> the frame is the zero-extended magnitude; sign_o carries the sign
module spm_operand_serializer #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             s_out_o,
  output logic             s_valid_o,
  output logic             s_first_o,
  output logic             s_last_o,
  output logic             sign_o
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [FRAME_LEN-1:0] shreg_q;
  logic [FRAME_LEN-1:0] shreg_d;
  logic                 s_out_q;
  logic                 s_valid_q;
  logic                 s_first_q;
  logic                 s_last_q;
  logic                 sign_q;

  logic                 last_cycle;
  logic                 accept;
  logic [FRAME_LEN-1:0] frame_load;
  logic                 load_fill;
  logic                 shift_fill;

  // The last bit of a frame doubles as the slot where the next operand can
  // be taken, which is what makes back-to-back frames gapless.
  assign last_cycle = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign in_ready_o = !rst_i && ((state_q == IDLE) || last_cycle);
  assign accept     = in_valid_i && in_ready_o;

`ifdef SPM_SERIALIZER_ABS_EN
  logic [WIDTH:0] in_wide;
  logic [WIDTH:0] in_mag;

  // Magnitude is formed one bit wider than the operand so that the most
  // negative value maps to +2^(WIDTH-1) instead of wrapping.
  always_comb begin
    in_wide    = {in_data_i[WIDTH-1], in_data_i};
    in_mag     = in_data_i[WIDTH-1] ? (~in_wide + (WIDTH+1)'(1)) : in_wide;
    frame_load = FRAME_LEN'(in_mag);
    load_fill  = 1'b0;
    shift_fill = 1'b0;
  end
`else
  // Frame is the operand sign-extended; the shifter keeps refilling with
  // the sign so the register always reads as the extended operand.
  always_comb begin
    frame_load = {{(FRAME_LEN-WIDTH){in_data_i[WIDTH-1]}}, in_data_i};
    load_fill  = in_data_i[WIDTH-1];
    shift_fill = sign_q;
  end
`endif

  // Next values of the bit counter and the remaining-bits shifter.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    shreg_d = {shift_fill, shreg_q[FRAME_LEN-1:1]};
  end

  // Frame sequencer: bit 0 is presented straight out of the load, and the
  // shifter holds the bits still to come, so every output is registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_first_q <= 1'b0;
      s_last_q  <= 1'b0;
      sign_q    <= 1'b0;
    end else if (accept) begin
      state_q   <= SHIFT;
      cnt_q     <= '0;
      shreg_q   <= {load_fill, frame_load[FRAME_LEN-1:1]};
      s_out_q   <= frame_load[0];
      s_valid_q <= 1'b1;
      s_first_q <= 1'b1;
      s_last_q  <= (LAST_CNT == '0);
      sign_q    <= in_data_i[WIDTH-1];
    end else if (state_q == SHIFT) begin
      if (last_cycle) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        s_out_q   <= 1'b0;
        s_valid_q <= 1'b0;
        s_first_q <= 1'b0;
        s_last_q  <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        shreg_q   <= shreg_d;
        s_out_q   <= shreg_q[0];
        s_first_q <= 1'b0;
        s_last_q  <= (cnt_d == LAST_CNT);
      end
    end
  end

  assign s_out_o   = s_out_q;
  assign s_valid_o = s_valid_q;
  assign s_first_o = s_first_q;
  assign s_last_o  = s_last_q;
  assign sign_o    = sign_q;

endmodule

// File: tb/tb_spm_operand_serializer.sv
// Directed bench for spm_operand_serializer (WIDTH=8, FRAME_LEN=16).
// Expected frames are hand-written constants for both builds of the
// SPM_SERIALIZER_ABS_EN option.
module tb_spm_operand_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       s_out;
  logic       s_valid;
  logic       s_first;
  logic       s_last;
  logic       sign;

  int checks;
  int failures;

`ifdef SPM_SERIALIZER_ABS_EN
  localparam logic [15:0] EXP_FB = 16'h0005;
  localparam logic [15:0] EXP_80 = 16'h0080;
`else
  localparam logic [15:0] EXP_FB = 16'hFFFB;
  localparam logic [15:0] EXP_80 = 16'hFF80;
`endif

  spm_operand_serializer #(
    .WIDTH    (8),
    .FRAME_LEN(16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .in_data_i (in_data),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .s_out_o   (s_out),
    .s_valid_o (s_valid),
    .s_first_o (s_first),
    .s_last_o  (s_last),
    .sign_o    (sign)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    rst      = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Idle state: no strobes, ready, sign still holding the last frame's value.
  task automatic checkIdle(input string tag, input logic expSign);
    checkOutput({tag, "_valid"}, 32'(s_valid), 32'd0);
    checkOutput({tag, "_first"}, 32'(s_first), 32'd0);
    checkOutput({tag, "_last"},  32'(s_last),  32'd0);
    checkOutput({tag, "_out"},   32'(s_out),   32'd0);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_sign"},  32'(sign),    32'(expSign));
  endtask

  // Called one cycle after the accept edge; walks all 16 frame bits.
  // When chain is set the next operand is offered in the s_last cycle.
  task automatic checkFrame(input string tag, input logic [15:0] frame,
                            input logic expSign, input logic holdValid,
                            input logic chain, input logic [7:0] nextData);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("%s_b%0d_valid", tag, i), 32'(s_valid), 32'd1);
      checkOutput($sformatf("%s_b%0d_out", tag, i),   32'(s_out),   32'(frame[i]));
      checkOutput($sformatf("%s_b%0d_first", tag, i), 32'(s_first), 32'(i == 0));
      checkOutput($sformatf("%s_b%0d_last", tag, i),  32'(s_last),  32'(i == 15));
      checkOutput($sformatf("%s_b%0d_ready", tag, i), 32'(in_ready), 32'(i == 15));
      checkOutput($sformatf("%s_b%0d_sign", tag, i),  32'(sign),    32'(expSign));
      if (i == 15 && chain)
        applyStimulus(1'b1, nextData, 1'b0);
      else
        applyStimulus(holdValid && (i != 15), 8'(i * 29 + 3), 1'b0);
      step();
    end
  endtask

  // Offer one operand in the current cycle and take it on the next edge.
  task automatic acceptOperand(input string tag, input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0);
    #1;
    checkOutput({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    applyStimulus(1'b1, 8'h5A, 1'b1);
    step();
    step();

    // Reset state; rst must also mask in_ready and win over in_valid.
    checkOutput("rst_valid", 32'(s_valid), 32'd0);
    checkOutput("rst_first", 32'(s_first), 32'd0);
    checkOutput("rst_last",  32'(s_last),  32'd0);
    checkOutput("rst_out",   32'(s_out),   32'd0);
    checkOutput("rst_sign",  32'(sign),    32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);

    // Idle hold with wiggling data and no valid.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'($urandom), 1'b0);
      step();
      checkOutput($sformatf("idle%0d_valid", i), 32'(s_valid), 32'd0);
      checkOutput($sformatf("idle%0d_ready", i), 32'(in_ready), 32'd1);
      checkOutput($sformatf("idle%0d_sign", i),  32'(sign),    32'd0);
    end

    // Positive operand.
    acceptOperand("pos", 8'h05);
    checkFrame("pos", 16'h0005, 1'b0, 1'b0, 1'b0, 8'h00);
    checkIdle("pos_end", 1'b0);

    // Negative operand.
    acceptOperand("neg", 8'hFB);
    checkFrame("neg", EXP_FB, 1'b1, 1'b0, 1'b0, 8'h00);
    checkIdle("neg_end", 1'b1);

    // Most negative operand.
    acceptOperand("min", 8'h80);
    checkFrame("min", EXP_80, 1'b1, 1'b0, 1'b0, 8'h00);
    checkIdle("min_end", 1'b1);

    // Back-to-back frames; valid stays high through the first frame.
    acceptOperand("b2b0", 8'h03);
    checkFrame("b2b0", 16'h0003, 1'b0, 1'b1, 1'b1, 8'h7F);
    checkFrame("b2b1", 16'h007F, 1'b0, 1'b0, 1'b0, 8'h00);
    checkIdle("b2b_end", 1'b0);

    // Reset during bit 6 of 0x55, with a competing valid operand.
    acceptOperand("mid", 8'h55);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("mid_b%0d_valid", i), 32'(s_valid), 32'd1);
      checkOutput($sformatf("mid_b%0d_out", i),   32'(s_out),   32'((i % 2) == 0));
      if (i < 6) begin
        applyStimulus(1'b0, 8'h00, 1'b0);
        step();
      end
    end
    applyStimulus(1'b1, 8'h01, 1'b1);
    step();
    checkOutput("midrst_valid", 32'(s_valid), 32'd0);
    checkOutput("midrst_first", 32'(s_first), 32'd0);
    checkOutput("midrst_last",  32'(s_last),  32'd0);
    checkOutput("midrst_out",   32'(s_out),   32'd0);
    checkOutput("midrst_sign",  32'(sign),    32'd0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    step();
    checkIdle("midrst_idle", 1'b0);

    // Fresh frame after the aborted one.
    acceptOperand("one", 8'h01);
    checkFrame("one", 16'h0001, 1'b0, 1'b0, 1'b0, 8'h00);
    checkIdle("one_end", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spm_operand_serializer.md
# spm_operand_serializer

Converts a parallel two's-complement operand into the LSB-first bit-serial stream consumed by the serial-parallel multiplier datapath, one bit per clock, sign-extended to a full frame. It is the producing end of the serial stream whose sign is re-applied downstream by the serial two's-complement negator. An optional mode strips the sign and emits the magnitude instead, with the sign reported on a separate flag.

## Interface
- WIDTH, 8, operand width in bits (two's complement)
- FRAME_LEN, 16, bits emitted per frame; must be >= WIDTH+1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  operand, two's complement
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept an operand this cycle
- s_out  out  1  serial data bit, LSB first
- s_valid  out  1  s_out carries a frame bit this cycle
- s_first  out  1  high on bit 0 of a frame
- s_last  out  1  high on bit FRAME_LEN-1 of a frame
- sign  out  1  MSB of the operand of the current frame; held until the next accept

## Operation
- The FSM has two states: IDLE and SHIFT.
- IDLE:
  - in_ready=1, s_valid=0.
  - On in_valid&&in_ready, the block loads the shift register with the operand extended to FRAME_LEN bits, latches sign=in_data[WIDTH-1], clears the bit counter, and enters SHIFT.
- SHIFT:
  - s_valid=1 and s_out=shreg[0].
  - Each cycle the shift register shifts right by one with fill (see Configuration) and the counter increments.
  - s_first=1 when count==0. s_last=1 when count==FRAME_LEN-1.
- End of frame:
  - in_ready=1 during the s_last cycle.
  - If an operand is accepted in that cycle, the next cycle starts a new frame in SHIFT with count=0, with no gap.
  - Otherwise the FSM returns to IDLE.
- in_ready=0 in SHIFT except in the s_last cycle.
- There is no downstream backpressure. The consumer takes one bit per clock unconditionally.
- in_data is sampled only at acceptance. Changes to in_data later in the frame have no effect.
- Reset values: state=IDLE, s_out=0, s_valid=0, s_first=0, s_last=0, sign=0, counter=0, shift register=0. in_ready=0 while rst is high.
- Reset mid-frame aborts the frame. All outputs take their reset values on the next edge, and no partial frame resumes.

## Timing
- Accept at edge k means bit 0 is on s_out in cycle k+1, and bit FRAME_LEN-1 (with s_last) in cycle k+FRAME_LEN.
- Latency from acceptance to first bit is 1 cycle. Throughput is one operand per FRAME_LEN cycles when fed back-to-back.
- s_out, s_valid, s_first, s_last and sign are registered outputs. in_ready is decoded combinationally from state/counter and rst.
- If in_valid and rst are both high, rst wins and nothing is accepted.

## Configuration
- Macro: SPM_SERIALIZER_ABS_EN.
- Undefined (default):
  - The shift register holds the sign-extended operand and the shift fill is the operand sign bit.
  - The frame equals in_data sign-extended to FRAME_LEN bits.
  - sign is informational only.
- Defined:
  - At acceptance, the shift register holds |in_data| as an unsigned WIDTH+1-bit value (in_data negated if its MSB is 1), zero-extended.
  - The shift fill is 0.
  - The most negative operand (-2^(WIDTH-1)) yields magnitude 2^(WIDTH-1), emitted correctly in bit WIDTH-1.
  - sign drives the downstream serial negator.

## Test plan
- Positive operand, WIDTH=8, FRAME_LEN=16: in_data=0x05 accepted at k -> s_out over k+1..k+16 = 1,0,1, then 13 zeros; s_first at k+1, s_last at k+16, sign=0; in_ready returns 1 at k+16.
- Negative operand: in_data=0xFB.
  - Without macro -> 0xFFFB LSB-first (1,1,0,1, then 12 ones), sign=1.
  - With SPM_SERIALIZER_ABS_EN -> 1,0,1, then 13 zeros, sign=1.
- Most negative: in_data=0x80.
  - Without macro -> 0xFF80.
  - With macro -> only bit 7 is 1, all other bits 0, sign=1.
- Back-to-back: in_valid held high with 0x03, then 0x7F accepted in the s_last cycle -> 32 consecutive s_valid cycles; s_first at cycles 1 and 17; second frame = 0x007F; no idle cycle between frames.
- Reset mid-frame: rst high during bit 6 of 0x55 -> next cycle s_valid=s_first=s_last=s_out=sign=0 and FSM in IDLE; a subsequent 0x01 frame emits 1, then 15 zeros, with correct strobes.
- Idle hold: in_valid=0 for 20 cycles after reset -> s_valid=0 and in_ready=1 throughout; a changing in_data has no effect.
